mem_store_buffer: RTL and testbench

Store buffer and data-memory port arbiter between the EX/MEM pipeline register and the 32-word data memory. Accepts one memory op per cycle, queues stores in a small FIFO and drains them to memory in idle slots. Loads go to memory directly, or are forwarded from the youngest matching buffered store. It is the only master driving the data-memory strobes.

---
 rtl/mem_store_buffer.sv | 170 +++++++++++++++++
 tb/tb_mem_store_buffer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_store_buffer.sv
// Store buffer and data-memory port arbiter between the EX/MEM register and the data memory.
// Queues stores in a FIFO and drains them in free memory slots. Loads either read memory or
// take data from the youngest matching buffered store. This block is the only master on the
// data-memory strobes. Every strobe cycle is followed by one cooldown cycle with no access.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   store_valid/ready/addr/data      store request handshake
//   load_valid/ready/addr            load request handshake
//   load_data/done/fwd               registered load result, one-cycle done pulse, forward flag
//   dm_addr/data/mem_write/mem_read  data-memory port (combinational, single-cycle strobes)
//   dm_read_data                     memory read data, valid in the read-strobe cycle
//   empty, count                     store buffer occupancy
module mem_store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          store_valid,
  output logic          store_ready,
  input  logic [AW-1:0] store_addr,
  input  logic [DW-1:0] store_data,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [AW-1:0] load_addr,
  output logic [DW-1:0] load_data,
  output logic          load_done,
  output logic          load_fwd,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_data,
  output logic          dm_mem_write,
  output logic          dm_mem_read,
  input  logic [DW-1:0] dm_read_data,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [AW-1:0] addr_q [DEPTH];
  logic [AW-1:0] addr_d [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [DW-1:0] data_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          cooldown_q, cooldown_d;
  logic [DW-1:0] load_data_q, load_data_d;
  logic          load_done_q, load_done_d;
  logic          load_fwd_q, load_fwd_d;

  logic          full;
  logic          push;
  logic          load_acc;
  logic          hit;
  logic [DW-1:0] hit_data;
  logic          drain;
  logic          rd;

  assign full        = (count_q == CW'(DEPTH));
  // A pending load takes precedence over a store; the store simply waits.
  assign store_ready = !full && !load_valid;
  assign load_ready  = !full && !cooldown_q;
  assign push        = store_valid && store_ready;
  assign load_acc    = load_valid && load_ready;

  // Scan oldest to youngest so the last match is the youngest store.
  always_comb begin
    logic [PW-1:0] idx;
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (addr_q[idx] == load_addr)) begin
        hit      = 1'b1;
        hit_data = data_q[idx];
      end
    end
  end

  // Slot arbitration: forced drain, then load, then opportunistic drain.
  always_comb begin
    drain = 1'b0;
    rd    = 1'b0;
    if (!reset && !cooldown_q) begin
      if (full) begin
        drain = 1'b1;
      end else if (load_acc) begin
        rd = !hit;
      end else if (count_q != '0) begin
        drain = 1'b1;
      end
    end
  end

  always_comb begin
    dm_addr      = '0;
    dm_data      = '0;
    dm_mem_write = drain;
    dm_mem_read  = rd;
    if (drain) begin
      dm_addr = addr_q[head_q];
      dm_data = data_q[head_q];
    end else if (rd) begin
      dm_addr = load_addr;
    end
  end

  always_comb begin
    addr_d      = addr_q;
    data_d      = data_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    cooldown_d  = drain || rd;
    load_data_d = load_data_q;
    load_done_d = 1'b0;
    load_fwd_d  = load_fwd_q;
    if (push) begin
      addr_d[tail_q] = store_addr;
      data_d[tail_q] = store_data;
      tail_d         = tail_q + PW'(1);
    end
    if (drain) begin
      head_d = head_q + PW'(1);
    end
    count_d = count_q + CW'(push) - CW'(drain);
    if (load_acc) begin
      load_done_d = 1'b1;
      load_fwd_d  = hit;
      load_data_d = hit ? hit_data : dm_read_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      cooldown_q  <= 1'b0;
      load_data_q <= '0;
      load_done_q <= 1'b0;
      load_fwd_q  <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      cooldown_q  <= cooldown_d;
      load_data_q <= load_data_d;
      load_done_q <= load_done_d;
      load_fwd_q  <= load_fwd_d;
    end
  end

  // Entry storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  assign load_data = load_data_q;
  assign load_done = load_done_q;
  assign load_fwd  = load_fwd_q;
  assign empty     = (count_q == '0);
  assign count     = count_q;

endmodule

// File: tb/tb_mem_store_buffer.sv
module tb_mem_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        store_valid, store_ready;
  logic [4:0]  store_addr;
  logic [31:0] store_data;
  logic        load_valid, load_ready;
  logic [4:0]  load_addr;
  logic [31:0] load_data;
  logic        load_done, load_fwd;
  logic [4:0]  dm_addr;
  logic [31:0] dm_data;
  logic        dm_mem_write, dm_mem_read;
  logic [31:0] dm_read_data;
  logic        empty;
  logic [2:0]  count;

  always #5 clk = ~clk;

  mem_store_buffer #(.DEPTH(4), .AW(5), .DW(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .store_valid  (store_valid),
    .store_ready  (store_ready),
    .store_addr   (store_addr),
    .store_data   (store_data),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_addr    (load_addr),
    .load_data    (load_data),
    .load_done    (load_done),
    .load_fwd     (load_fwd),
    .dm_addr      (dm_addr),
    .dm_data      (dm_data),
    .dm_mem_write (dm_mem_write),
    .dm_mem_read  (dm_mem_read),
    .dm_read_data (dm_read_data),
    .empty        (empty),
    .count        (count)
  );

  // Data memory model: preloaded once, never touched by reset.
  logic [31:0] mem [32];
  logic        mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'hCAFE_0000 + 32'(i);
      mem[9]   <= 32'h0000_1234;
      mem_init <= 1'b1;
    end else if (dm_mem_write) begin
      mem[dm_addr] <= dm_data;
    end
  end
  assign dm_read_data = mem[dm_addr];

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        fwd;
  } exp_t;
  exp_t exp_q[$];

  logic prev_strobe = 1'b0;
  logic rd_seen     = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Monitor: scoreboard pop on load_done, plus strobe spacing.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (prev_strobe) chk("strobe_after_strobe", {30'b0, dm_mem_write, dm_mem_read}, 32'h0);
      if (load_done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_load_done", 32'h1, 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("load_data", load_data, e.data);
          chk("load_fwd", {31'b0, load_fwd}, {31'b0, e.fwd});
        end
      end
      if (dm_mem_read) rd_seen = 1'b1;
    end
    prev_strobe = !reset && (dm_mem_write || dm_mem_read);
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Issue a load, retrying while load_ready is low; records the accept-cycle memory port.
  task automatic do_load(input logic [4:0] a, input logic [31:0] ed, input logic ef,
                         output int waits, output logic acc_rd, output logic [4:0] acc_addr);
    logic acc = 1'b0;
    waits    = 0;
    acc_rd   = 1'b0;
    acc_addr = '0;
    load_valid = 1'b1;
    load_addr  = a;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (load_ready) begin
        exp_q.push_back('{data: ed, fwd: ef});
        acc_rd   = dm_mem_read;
        acc_addr = dm_addr;
        acc      = 1'b1;
        break;
      end
      waits++;
      next();
    end
    if (!acc) chk("load_accept_timeout", 32'h0, 32'h1);
    next();
    load_valid = 1'b0;
  endtask

  initial begin
    int          w;
    logic        r;
    logic [4:0]  a;
    int          n;
    reset       = 1'b1;
    store_valid = 1'b0;
    store_addr  = '0;
    store_data  = '0;
    load_valid  = 1'b0;
    load_addr   = '0;
    next();
    next();
    reset = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_dm_write", 32'(dm_mem_write), 32'd0);

    // Single store then drain and cooldown.
    next();
    store_valid = 1'b1; store_addr = 5'd3; store_data = 32'hDEAD_BEEF;
    #1;
    chk("t1_store_ready", 32'(store_ready), 32'd1);
    next();
    store_valid = 1'b0;
    #1;
    chk("t1_count", 32'(count), 32'd1);
    chk("t1_drain_we", 32'(dm_mem_write), 32'd1);
    chk("t1_drain_addr", 32'(dm_addr), 32'd3);
    chk("t1_drain_data", dm_data, 32'hDEAD_BEEF);
    next();
    chk("t1_cool_strobes", {30'b0, dm_mem_write, dm_mem_read}, 32'h0);
    chk("t1_cool_empty", 32'(empty), 32'd1);
    chk("t1_cool_load_ready", 32'(load_ready), 32'd0);
    next();

    // Two stores to one address, load forwards the younger one.
    rd_seen = 1'b0;
    store_valid = 1'b1; store_addr = 5'd7; store_data = 32'h11;
    next();
    store_data = 32'h22;
    next();
    store_valid = 1'b0;
    do_load(5'd7, 32'h22, 1'b1, w, r, a);
    chk("t2_wait_cooldown", 32'(w), 32'd1);
    #1;
    chk("t2_drain_we", 32'(dm_mem_write), 32'd1);
    chk("t2_drain_data", dm_data, 32'h22);
    chk("t2_no_read", 32'(rd_seen), 32'd0);
    next();
    next();
    chk("t2_mem7", mem[7], 32'h22);

    // Memory load on empty buffer.
    do_load(5'd9, 32'h1234, 1'b0, w, r, a);
    chk("t3_wait", 32'(w), 32'd0);
    chk("t3_read", 32'(r), 32'd1);
    chk("t3_addr", 32'(a), 32'd9);
    #1;
    chk("t3_cool_load_ready", 32'(load_ready), 32'd0);
    next();

    // Back-to-back memory loads: the second waits out the cooldown.
    do_load(5'd1, 32'hCAFE_0001, 1'b0, w, r, a);
    chk("t5_first_wait", 32'(w), 32'd0);
    do_load(5'd2, 32'hCAFE_0002, 1'b0, w, r, a);
    chk("t5_second_wait", 32'(w), 32'd1);
    chk("t5_second_addr", 32'(a), 32'd2);
    next();
    next();
    chk("t5_hold_data", load_data, 32'hCAFE_0002);
    chk("t5_hold_done", 32'(load_done), 32'd0);
    next();

    // Stream stores until the buffer fills.
    n = 0;
    for (int i = 0; i < 20; i++) begin
      store_valid = 1'b1;
      store_addr  = 5'(16 + i);
      store_data  = 32'h100 + 32'(i);
      #1;
      if (!store_ready) break;
      n++;
      next();
    end
    chk("t4_pushes", 32'(n), 32'd7);
    chk("t4_full_count", 32'(count), 32'd4);
    chk("t4_full_store_ready", 32'(store_ready), 32'd0);
    chk("t4_full_load_ready", 32'(load_ready), 32'd0);
    chk("t4_forced_we", 32'(dm_mem_write), 32'd1);
    chk("t4_forced_addr", 32'(dm_addr), 32'd19);
    chk("t4_forced_data", dm_data, 32'h103);
    store_valid = 1'b0;
    next();
    chk("t4_after_count", 32'(count), 32'd3);
    chk("t4_after_store_ready", 32'(store_ready), 32'd1);
    next();
    chk("t6_pre_count", 32'(count), 32'd3);
    chk("t6_pre_we", 32'(dm_mem_write), 32'd1);

    // Reset with three stores pending.
    reset = 1'b1;
    #1;
    chk("t6_rst_strobe", 32'(dm_mem_write), 32'd0);
    next();
    reset = 1'b0;
    #1;
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_empty", 32'(empty), 32'd1);
    chk("t6_load_data", load_data, 32'h0);
    chk("t6_load_fwd", 32'(load_fwd), 32'd0);
    chk("t6_dm_addr", 32'(dm_addr), 32'd0);
    chk("t6_dm_data", dm_data, 32'h0);
    chk("t6_mem19", mem[19], 32'h103);
    chk("t6_mem20", mem[20], 32'hCAFE_0014);
    next();
    do_load(5'd21, 32'hCAFE_0015, 1'b0, w, r, a);
    chk("t6_load21_read", 32'(r), 32'd1);
    do_load(5'd19, 32'h103, 1'b0, w, r, a);
    next();
    next();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running, required finished");
    $fatal(1);
  end

endmodule
